// File: rtl/min_scan_if.sv
// Request/memory bundle between the minimum-scan engine and its host plus data memory.
interface min_scan_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [31:0]      base_adr;
  logic [CNT_W-1:0] count;
  logic [31:0]      mem_rdata;
  logic [31:0]      mem_adr;
  logic [31:0]      mem_wdata;
  logic             mem_rd;
  logic             mem_wr;
  logic             busy;
  logic             done;
  logic [31:0]      min_val;
  logic [31:0]      min_idx;

  modport master (
    input  start, base_adr, count, mem_rdata,
    output mem_adr, mem_wdata, mem_rd, mem_wr, busy, done, min_val, min_idx
  );

  modport slave (
    output start, base_adr, count, mem_rdata,
    input  mem_adr, mem_wdata, mem_rd, mem_wr, busy, done, min_val, min_idx
  );
endinterface

// File: rtl/min_scan_engine.sv
// Scans count signed words from base_adr, tracks the minimum and its index,
// then writes both to RES_ADR / RES_ADR+4 of the data memory.
module min_scan_engine #(
  parameter logic [31:0] RES_ADR = 32'd2000,
  parameter int          CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  min_scan_if.master bus
);
  typedef enum logic [2:0] {IDLE, READ, WR_MIN, WR_IDX, DONE} state_t;

  state_t           r_state;
  logic [31:0]      r_base;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_i;
  logic [31:0]      r_min_val;
  logic [CNT_W-1:0] r_min_idx;

  logic [31:0]      w_adr;
  logic [31:0]      w_wdata;
  logic             w_rd;
  logic             w_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_base    <= '0;
      r_cnt     <= '0;
      r_i       <= '0;
      r_min_val <= '0;
      r_min_idx <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_base    <= bus.base_adr;
          r_cnt     <= bus.count;
          r_i       <= '0;
          r_min_val <= 32'h7FFF_FFFF;
          r_min_idx <= '0;
          r_state   <= (bus.count != '0) ? READ : WR_MIN;
        end
        READ: begin
          // strict compare keeps the earliest index on ties
          if ($signed(bus.mem_rdata) < $signed(r_min_val)) begin
            r_min_val <= bus.mem_rdata;
            r_min_idx <= r_i;
          end
          r_i <= r_i + CNT_W'(1);
          if (r_i == r_cnt - CNT_W'(1)) r_state <= WR_MIN;
        end
        WR_MIN:  r_state <= WR_IDX;
        WR_IDX:  r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory strobes decode from registered state only, so reset kills them at once.
  always_comb begin
    w_adr   = '0;
    w_wdata = '0;
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    case (r_state)
      READ: begin
        w_rd  = 1'b1;
        w_adr = r_base + 32'({r_i, 2'b00});
      end
      WR_MIN: begin
        w_wr    = 1'b1;
        w_adr   = RES_ADR;
        w_wdata = r_min_val;
      end
      WR_IDX: begin
        w_wr    = 1'b1;
        w_adr   = RES_ADR + 32'd4;
        w_wdata = 32'(r_min_idx);
      end
      default: ;
    endcase
  end

  assign bus.mem_adr   = w_adr;
  assign bus.mem_wdata = w_wdata;
  assign bus.mem_rd    = w_rd;
  assign bus.mem_wr    = w_wr;
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == DONE);
  assign bus.min_val   = r_min_val;
  assign bus.min_idx   = 32'(r_min_idx);
endmodule

// File: tb/tb_min_scan_engine.sv
// Directed bench for min_scan_engine with a word-array memory model and bus monitors.
module tb_min_scan_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  min_scan_if #(.CNT_W(16)) bus ();
  min_scan_engine #(.RES_ADR(32'd2000), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] img [0:1023];
  assign bus.mem_rdata = img[bus.mem_adr[11:2]];

  // Bus monitors: read address log, result writes, strobe overlap.
  logic [31:0] rd_log [0:63];
  logic [31:0] rd_cnt = 0, wr_cnt = 0, ovl_cnt = 0;
  logic [31:0] last_min = 32'hDEAD_BEEF, last_idx = 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (bus.mem_rd) begin
      rd_log[rd_cnt[5:0]] <= bus.mem_adr;
      rd_cnt <= rd_cnt + 1;
    end
    if (bus.mem_wr) begin
      wr_cnt <= wr_cnt + 1;
      if (bus.mem_adr == 32'd2000) last_min <= bus.mem_wdata;
      if (bus.mem_adr == 32'd2004) last_idx <= bus.mem_wdata;
    end
    if (bus.mem_rd && bus.mem_wr) ovl_cnt <= ovl_cnt + 1;
  end

  typedef struct {
    logic [31:0]       base;
    int                n;
    logic [19:0][31:0] w;
    logic [31:0]       emin;
    logic [31:0]       eidx;
  } vec_t;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_req(input logic [31:0] base, input int n);
    bus.start    = 1'b1;
    bus.base_adr = base;
    bus.count    = 16'(n);
    @(posedge clk); #1;
    bus.start    = 1'b0;
  endtask

  // inj>0: pulse a conflicting start in that busy cycle, which must be ignored.
  task automatic run_vec(input vec_t v, input string tag, input int inj);
    logic [31:0] r0, w0;
    int cyc, bad_adr;
    for (int k = 0; k < v.n; k++) img[int'(v.base[11:2]) + k] = v.w[k];
    r0 = rd_cnt;
    w0 = wr_cnt;
    start_req(v.base, v.n);
    cyc = 1;
    while (!bus.done && cyc < 200) begin
      if (cyc == inj) begin
        bus.start = 1'b1; bus.base_adr = 32'h100; bus.count = 16'd4;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    chk({tag, " done_cycle"}, 32'(cyc), 32'(v.n + 3));
    chk({tag, " min_val"}, bus.min_val, v.emin);
    chk({tag, " min_idx"}, bus.min_idx, v.eidx);
    chk({tag, " n_reads"}, rd_cnt - r0, 32'(v.n));
    chk({tag, " n_writes"}, wr_cnt - w0, 32'd2);
    chk({tag, " mem2000"}, last_min, v.emin);
    chk({tag, " mem2004"}, last_idx, v.eidx);
    bad_adr = 0;
    for (int k = 0; k < v.n; k++)
      if (rd_log[6'(r0 + 32'(k))] !== v.base + 32'(4 * k)) bad_adr++;
    chk({tag, " read_order_errs"}, 32'(bad_adr), 32'd0);
    @(posedge clk); #1;
    chk({tag, " busy_after_done"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    vec_t v [6];
    logic [31:0] d20 [0:19];
    logic [31:0] w0;
    int cyc;
    d20 = '{32'd5, 32'd9, 32'hFFFF_FFFD, 32'd7, 32'd11, 32'd4, 32'd8, 32'd6, 32'd2, 32'd10,
            32'd3, 32'd15, 32'd14, 32'd1, 32'd13, 32'd0, 32'd16, 32'd17, 32'd18, 32'd12};
    for (int i = 0; i < 1024; i++) img[i] = 32'h5555_0000 + 32'(i);
    for (int i = 0; i < 6; i++) begin
      v[i].w = '0; v[i].n = 0; v[i].base = '0; v[i].emin = '0; v[i].eidx = '0;
    end
    v[0].base = 32'h0;   v[0].n = 20; v[0].emin = 32'hFFFF_FFFD; v[0].eidx = 32'd2;
    for (int k = 0; k < 20; k++) v[0].w[k] = d20[k];
    v[1].base = 32'h100; v[1].n = 4;  v[1].emin = 32'd1;         v[1].eidx = 32'd1;
    v[1].w[0] = 32'd4; v[1].w[1] = 32'd1; v[1].w[2] = 32'd1; v[1].w[3] = 32'd8;
    v[2].base = 32'h200; v[2].n = 3;  v[2].emin = 32'h8000_0000; v[2].eidx = 32'd1;
    v[2].w[0] = 32'h7FFF_FFFF; v[2].w[1] = 32'h8000_0000; v[2].w[2] = 32'd0;
    v[3].base = 32'h300; v[3].n = 0;  v[3].emin = 32'h7FFF_FFFF; v[3].eidx = 32'd0;
    v[4].base = 32'h40;  v[4].n = 3;  v[4].emin = 32'd1;         v[4].eidx = 32'd2;
    v[4].w[0] = 32'd3; v[4].w[1] = 32'd2; v[4].w[2] = 32'd1;
    v[5].base = 32'h80;  v[5].n = 1;  v[5].emin = 32'hFFFF_FFFB; v[5].eidx = 32'd0;
    v[5].w[0] = 32'hFFFF_FFFB;

    bus.start = 1'b0; bus.base_adr = '0; bus.count = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset min_val", bus.min_val, 32'd0);
    chk("reset min_idx", bus.min_idx, 32'd0);
    chk("reset strobes", {28'd0, bus.busy, bus.done, bus.mem_rd, bus.mem_wr}, 32'd0);
    chk("reset mem_adr", bus.mem_adr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(v[i], $sformatf("vec%0d", i), 0);

    // Restart of a 20-word scan with a conflicting start pulsed in cycle 3.
    for (int k = 0; k < 4; k++) img[64 + k] = 32'h8000_0000;
    run_vec(v[0], "ignored_start", 3);

    // Reset in cycle 5 of a 20-word scan: no result writes may follow.
    w0 = wr_cnt;
    start_req(32'h0, 20);
    cyc = 1;
    while (cyc < 5) begin @(posedge clk); #1; cyc++; end
    chk("pre_reset busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset strobes", {29'd0, bus.busy, bus.mem_rd, bus.mem_wr}, 32'd0);
    chk("mid_reset mem_adr", bus.mem_adr, 32'd0);
    chk("mid_reset min_val", bus.min_val, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("post_reset no_writes", wr_cnt - w0, 32'd0);
    run_vec(v[1], "after_reset", 0);

    chk("rd_wr_overlap", ovl_cnt, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/min_scan_engine.md
# min_scan_engine

Hardware initiator for the byte-addressed, little-endian data memory of the multi-cycle MIPS. It scans `count` consecutive 32-bit signed words starting at `base_adr`, finds the minimum and its index, and writes the results back to memory at `RES_ADR` and `RES_ADR+4`. These are the same locations the MIN20 program fills, so results can be checked through the memory's `two_thousand` and `two_thousand_four` taps. It drives the memory's `adr`/`d_in`/`mrd`/`mwr` inputs and consumes its combinational `d_out`.

## Interface
- `RES_ADR`, 32'd2000: byte address for the minimum value; the index goes to `RES_ADR+4`.
- `CNT_W`, 16: width of `count` and of the internal index.
- Reset is asynchronous, active-low (`rst_n`); single clock `clk`.
- `clk` in 1: the only clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `base_adr` in 32: byte address of element 0; latched on accepted `start`.
- `count` in CNT_W: number of words to scan; latched on accepted `start`.
- `mem_rdata` in 32: memory `d_out`, valid in the same cycle while `mem_rd`=1.
- `mem_adr` out 32: memory `adr`.
- `mem_wdata` out 32: memory `d_in`.
- `mem_rd` out 1: memory `mrd`.
- `mem_wr` out 1: memory `mwr`; memory writes on the rising edge while high.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after both result writes.
- `min_val` out 32: registered running/final minimum (signed).
- `min_idx` out 32: registered index of the minimum, zero-extended.

## Operation
- States: IDLE, READ, WR_MIN, WR_IDX, DONE.
- IDLE:
  - `start`=1 latches `base_adr` and `count`, sets i=0, min_val=32'h7FFF_FFFF, min_idx=0.
  - Goes to READ if count≠0, else WR_MIN.
- READ:
  - `mem_rd`=1, `mem_adr`=base+4·i (32-bit, wraps mod 2^32, no alignment check).
  - At the edge, if signed `mem_rdata` < min_val: min_val←`mem_rdata`, min_idx←i. The comparison is strict, so the first occurrence wins ties.
  - i←i+1. When i = count−1 is sampled, go to WR_MIN.
- WR_MIN: `mem_wr`=1, `mem_adr`=RES_ADR, `mem_wdata`=min_val; go to WR_IDX.
- WR_IDX: `mem_wr`=1, `mem_adr`=RES_ADR+4, `mem_wdata`=min_idx; go to DONE.
- DONE: `done`=1 for one cycle; return to IDLE. `min_val` and `min_idx` hold until the next accepted start.
- `mem_rd` and `mem_wr` are never high together. Outside READ/WR_* both are 0 and `mem_adr`/`mem_wdata` are 0.
- count=0: no reads are issued; writes 32'h7FFF_FFFF and 0.
- `start` while busy is ignored; latched operands are unaffected.

## Timing
- Reset values: all outputs 0, state IDLE. `min_val` resets to 0; it is loaded with 32'h7FFF_FFFF only on start.
- `start` is sampled at edge 0. Reads occupy cycles 1..N, WR_MIN is cycle N+1, WR_IDX is cycle N+2, and `done` is high in cycle N+3.
- Total latency from start to done is N+3 cycles (3 for N=0). `busy` is high in cycles 1..N+3.
- `mem_*` outputs are decoded from registered state/index only: no combinational path from `mem_rdata` or `start` to any output.
- A new `start` is accepted in the cycle after DONE at the earliest.
- Reset mid-operation: outputs drop to 0 immediately and any pending write is not issued. Memory contents already written remain.

## Test plan
- 20 words at base 0x0 = {5, 9, −3, 7, …, 12}, min −3 at index 2, count=20, start → done at cycle 23; mem[2000]=32'hFFFF_FFFD, mem[2004]=2; exactly 20 reads at addresses 0..76 in order.
- Ties {4, 1, 1, 8}, count=4 → min_val=1, min_idx=1 (first occurrence).
- Signed extremes {0x7FFF_FFFF, 0x8000_0000, 0}, count=3 → min=0x8000_0000, idx=1.
- count=0 → no `mem_rd`; writes 0x7FFF_FFFF and 0; `done` at cycle 3.
- `start` pulsed again in READ with different base/count → ignored; results match the first request.
- `rst_n` low during cycle 5 of a 20-word scan → outputs 0 at once, no writes to 2000/2004. A new start after release completes correctly.
